// File: rtl/demux_1x2_32bit_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x2_32bit_buffered
// Description : 1-to-2 valid/ready demux; each output path owns a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x2_32bit_buffered #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                in_data,
  input  logic                       select,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [31:0]                out_data1,
  output logic                       out_valid1,
  input  logic                       out_ready1,
  output logic [31:0]                out_data2,
  output logic                       out_valid2,
  input  logic                       out_ready2,
  output logic [$clog2(DEPTH):0]     level1,
  output logic [$clog2(DEPTH):0]     level2
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_lvl_w  = c_addr_w + 1;

  logic [1:0]              w_full;
  logic [1:0]              w_out_ready;
  logic [1:0][31:0]        w_head;
  logic [1:0][c_lvl_w-1:0] w_level;
  logic                    w_accept;

  assign w_out_ready = {out_ready2, out_ready1};

  // Ready looks only at the selected path's own fullness, never at pops.
  assign in_ready = ~w_full[select];
  assign w_accept = in_valid & in_ready;

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_path
      logic [31:0]         r_mem [DEPTH];
      logic [c_addr_w-1:0] r_wr_ptr;
      logic [c_addr_w-1:0] r_rd_ptr;
      logic [c_lvl_w-1:0]  r_level;
      logic                w_push;
      logic                w_pop;

      assign w_push = w_accept & (select == 1'(p));
      assign w_pop  = (r_level != '0) & w_out_ready[p];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_level  <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
        end else begin
          if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= r_wr_ptr + c_addr_w'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
          end
          case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_lvl_w'(1);
            2'b01:   r_level <= r_level - c_lvl_w'(1);
            default: r_level <= r_level;
          endcase
        end
      end

      assign w_full[p]  = (r_level == c_lvl_w'(DEPTH));
      assign w_level[p] = r_level;
      // Head comes straight from storage registers, so in_data never reaches it.
      assign w_head[p]  = r_mem[r_rd_ptr];
    end
  endgenerate

  assign out_data1  = w_head[0];
  assign out_data2  = w_head[1];
  assign level1     = w_level[0];
  assign level2     = w_level[1];
  assign out_valid1 = (w_level[0] != '0);
  assign out_valid2 = (w_level[1] != '0);

endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_32bit_buffered.sv
`default_nettype none
// Bench for demux_1x2_32bit_buffered: queue model checked every negedge plus
// hand-computed literal expectations for the directed scenarios.
module tb_demux_1x2_32bit_buffered;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] in_data = '0;
  logic        select = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data1, out_data2;
  logic        out_valid1, out_valid2;
  logic        out_ready1 = 1'b0;
  logic        out_ready2 = 1'b0;
  logic [1:0]  level1, level2;

  demux_1x2_32bit_buffered #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .select(select), .in_valid(in_valid), .in_ready(in_ready),
    .out_data1(out_data1), .out_valid1(out_valid1), .out_ready1(out_ready1),
    .out_data2(out_data2), .out_valid2(out_valid2), .out_ready2(out_ready2),
    .level1(level1), .level2(level2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic model_ready();
    return select ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
  endfunction

  // Model: acceptance decided on pre-edge occupancy, then pops, then the push.
  always @(posedge clk) begin
    bit acc;
    if (reset_n) begin
      acc = in_valid && model_ready();
      if (out_ready1 && q1.size() > 0) void'(q1.pop_front());
      if (out_ready2 && q2.size() > 0) void'(q2.pop_front());
      if (acc) begin
        if (select) q2.push_back(in_data);
        else        q1.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid1", {31'b0, out_valid1}, {31'b0, q1.size() != 0});
      check("valid2", {31'b0, out_valid2}, {31'b0, q2.size() != 0});
      check("level1", {30'b0, level1}, q1.size());
      check("level2", {30'b0, level2}, q2.size());
      check("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
      if (q1.size() != 0) check("data1", out_data1, q1[0]);
      if (q2.size() != 0) check("data2", out_data2, q2[0]);
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic s,
                       input logic r1, input logic r2);
    in_valid = v; in_data = d; select = s; out_ready1 = r1; out_ready2 = r2;
    @(posedge clk); #1;
  endtask

  // Hold a word until accepted; readies are randomised every cycle.
  task automatic send_rand(input logic [31:0] d, input logic s);
    logic acc;
    int   n;
    n = 0;
    in_valid = 1'b1; in_data = d; select = s;
    do begin
      out_ready1 = 1'($urandom_range(0, 1));
      out_ready2 = 1'($urandom_range(0, 1));
      #1 acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 32'(n), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    #7 reset_n = 1'b0;
    #1;
    check("rst_valid1", {31'b0, out_valid1}, 32'd0);
    check("rst_valid2", {31'b0, out_valid2}, 32'd0);
    check("rst_data1", out_data1, 32'd0);
    check("rst_data2", out_data2, 32'd0);
    check("rst_level1", {30'b0, level1}, 32'd0);
    check("rst_level2", {30'b0, level2}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Single word to path 1.
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("single_valid1", {31'b0, out_valid1}, 32'd1);
    check("single_data1", out_data1, 32'hDEADBEEF);
    check("single_level1", {30'b0, level1}, 32'd1);
    check("single_valid2", {31'b0, out_valid2}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("pop_level1", {30'b0, level1}, 32'd0);
    check("pop_valid1", {31'b0, out_valid1}, 32'd0);

    // Fill path 2, then steer to path 1 while path 2 is full.
    drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    check("full_level2", {30'b0, level2}, 32'd2);
    in_valid = 1'b1; in_data = 32'h33; select = 1'b1;
    #1 check("full_ready_sel1", {31'b0, in_ready}, 32'd0);
    select = 1'b0;
    #1 check("full_ready_sel0", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("p1_data_33", out_data1, 32'h33);
    check("drain2_first", out_data2, 32'h11);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("drain2_second", out_data2, 32'h22);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("drain2_empty", {31'b0, out_valid2}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Simultaneous push and pop on path 1.
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("pushpop_level1", {30'b0, level1}, 32'd1);
    check("pushpop_head", out_data1, 32'hB);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 20-word alternating stream with random back-pressure.
    for (int i = 0; i < 20; i++) send_rand(32'h1000 + 32'(i), 1'(i));
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("stream_empty1", {30'b0, level1}, 32'd0);
    check("stream_empty2", {30'b0, level2}, 32'd0);

    // Path 2 stalled full for 10 cycles; path 1 keeps accepting.
    drive(1'b1, 32'h2001, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h2002, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h3000 + 32'(i); select = 1'b0;
      out_ready1 = 1'b1; out_ready2 = 1'b0;
      #1 check("stall_ready1", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check("stall_head1", out_data1, 32'h3000 + 32'(i));
    end
    check("stall_level2", {30'b0, level2}, 32'd2);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Reset mid-operation with both paths full.
    drive(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h51, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h52, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_level1", {30'b0, level1}, 32'd2);
    check("pre_rst_level2", {30'b0, level2}, 32'd2);
    #2 reset_n = 1'b0;
    q1.delete();
    q2.delete();
    #1;
    check("mid_rst_valid1", {31'b0, out_valid1}, 32'd0);
    check("mid_rst_valid2", {31'b0, out_valid2}, 32'd0);
    check("mid_rst_data1", out_data1, 32'd0);
    check("mid_rst_data2", out_data2, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      check("post_rst_valid1", {31'b0, out_valid1}, 32'd0);
      check("post_rst_valid2", {31'b0, out_valid2}, 32'd0);
    end
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("post_rst_push", out_data2, 32'h77);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
